pipeline_stall_ctrl: RTL

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

---
 rtl/pipeline_stall_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: RUN/ISTALL/DSTALL/HALTED FSM with combinational stage enables.
// Define STALL_CNT_EN to add the saturating stall_cycles counter port.
module pipeline_stall_ctrl
`ifdef STALL_CNT_EN
#(
  parameter int unsigned WORD_SIZE = 16
)
`endif
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_use,
  input  logic                 imem_ready,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  input  logic                 mispredict,
  input  logic                 halt,
  output logic                 pc_write,
  output logic                 ifid_hold,
  output logic                 idex_write,
  output logic                 exmem_write,
  output logic                 ifid_flush,
  output logic                 idex_bubble,
  output logic [1:0]           state
`ifdef STALL_CNT_EN
  ,
  output logic [WORD_SIZE-1:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ISTALL = 2'd1,
    DSTALL = 2'd2,
    HALTED = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   d_miss;

  assign d_miss = dmem_req && !dmem_ready;
  assign state  = state_q;

  // ISTALL and DSTALL decode exactly like RUN; they only record which wait is in progress.
  always_comb begin
    pc_write    = 1'b1;
    ifid_hold   = 1'b0;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = RUN;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_hold   = 1'b1;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
    end else if (halt || state_q == HALTED || d_miss) begin
      pc_write    = 1'b0;
      ifid_hold   = 1'b1;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      state_d     = (halt || state_q == HALTED) ? HALTED : DSTALL;
    end else if (mispredict) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
    end else if (!imem_ready) begin
      pc_write    = 1'b0;
      ifid_flush  = 1'b1;
      state_d     = ISTALL;
    end else if (ld_use) begin
      pc_write    = 1'b0;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

`ifdef STALL_CNT_EN
  logic [WORD_SIZE-1:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_write && state_q != HALTED && stall_cycles_q != '1)
      stall_cycles_d = stall_cycles_q + WORD_SIZE'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cycles_q <= '0;
    else       stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
